// File: rtl/merak_channel_arbiter_pkg.sv
// Shared widths and state encoding for the Merak channel arbiter.
// Imported by the interface, the decoder and the arbiter top.
package merak_pkg;
  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;
endpackage

// File: rtl/merak_channel_arbiter_if.sv
// Request/grant bundle between the requesters and the arbiter.
// The master drives req; the slave (the arbiter) drives the grant side.
interface merak_channel_arbiter_if;
  import merak_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             hold_expired;

  modport master (
    output req,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid,
    input  hold_expired
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_idx,
    output gnt_valid,
    output hold_expired
  );
endinterface

// File: rtl/merak_channel_arbiter_dec.sv
// 3-to-8 one-hot decoder.
// Turns the registered grant index into the raw grant vector.
module Decoder3to8 (
  input  logic [2:0] a_i,
  output logic [7:0] y_o
);
  always_comb begin
    y_o = 8'd0;
    y_o[a_i] = 1'b1;
  end
endmodule

// File: rtl/merak_channel_arbiter.sv
// Round-robin arbiter sharing the Merak channel among 8 requesters.
// Grant is held while the owner requests, bounded by MAX_HOLD cycles.
module merak_channel_arbiter
  import merak_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  merak_channel_arbiter_if.slave  bus
);
  localparam int CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

  state_e           state_q;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] idx_q;
  logic             valid_q;
  logic             hexp_q;
  logic [CNT_W-1:0] cnt_q;

  logic [IDX_W-1:0] win_d;
  logic [N_REQ-1:0] raw_gnt;

  // Lowest rotated offset from ptr wins, hence the descending scan.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [N_REQ-1:0] r,
    input logic [IDX_W-1:0] p
  );
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;
    pick = p;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = p + IDX_W'(k);
      if (r[cand]) pick = cand;
    end
    return pick;
  endfunction

  assign win_d = rr_pick(bus.req, ptr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      hexp_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      hexp_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (|bus.req) begin
            idx_q   <= win_d;
            valid_q <= 1'b1;
            cnt_q   <= '0;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (!bus.req[idx_q] || cnt_q == CNT_LAST) begin
            valid_q <= 1'b0;
            ptr_q   <= idx_q + IDX_W'(1);
            hexp_q  <= bus.req[idx_q];
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  Decoder3to8 u_dec (
    .a_i (idx_q),
    .y_o (raw_gnt)
  );

  assign bus.gnt          = raw_gnt & {N_REQ{valid_q}};
  assign bus.gnt_idx      = idx_q;
  assign bus.gnt_valid    = valid_q;
  assign bus.hold_expired = hexp_q;
endmodule
